mips_multicycle_control: RTL
============================

Name: mips_multicycle_control

Overview:
- Multi-cycle control FSM for the next-generation MIPS core.
- The datapath becomes multi-cycle with one shared instruction/data memory, so instruction fetch and data access both use a variable-latency req/ready handshake.
- Sits between the instruction register / ALU zero flag and every datapath mux, write-enable and ALU-op select.
- Adds memory wait states, a memory timeout trap, an illegal-opcode trap and a retired-instruction counter.

Parameters:
- MEM_TIMEOUT, 15: maximum cycles mem_req may stay high without mem_ready before a trap (1..255).
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  reset is asynchronous and active-low.
- op  in  6  instruction bits [31:26], taken from the instruction register.
- funct  in  6  instruction bits [5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request.
- mem_we  out  1  write request (valid with mem_req).
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load the instruction register.
- pc_write  out  1  load the PC.
- pc_src  out  2  PC source: 0 = ALU result, 1 = ALUOut, 2 = jump target, 3 = rs.
- reg_write  out  1  register file write enable.
- reg_dst  out  2  destination register: 0 = rt, 1 = rd, 2 = $31.
- mem_to_reg  out  2  write-back data: 0 = ALUOut, 1 = MDR, 2 = PC.
- alu_src_a  out  2  ALU A: 0 = PC, 1 = rs, 2 = shamt.
- alu_src_b  out  2  ALU B: 0 = rt, 1 = constant 4, 2 = sign-extended imm, 3 = sign-extended imm << 2.
- alu_op  out  3  ALU operation class.
- trap  out  1  sticky fault flag.
- trap_cause  out  2  fault cause: 0 = none, 1 = illegal opcode, 2 = memory timeout.
- instr_count  out  CNT_W  number of retired instructions.

Behaviour:
- **Reset (reset = 0, async):**
  - State goes to FETCH; trap, trap_cause, instr_count and the timeout counter go to 0.
  - All outputs not listed below are 0 in every state.
- **FETCH:** mem_req = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 1, alu_op = ADD.
  - If mem_ready = 1: ir_write = 1, pc_write = 1, pc_src = 0, next state DECODE.
  - Otherwise stay in FETCH and increment the timeout counter.
- **DECODE:** alu_src_a = 0, alu_src_b = 3, alu_op = ADD (computes the branch target). Next state by op:
  - 0x00, funct 0x08: JR.
  - 0x00, funct 0x00 or 0x02: SHIFT.
  - 0x00, any other funct: EXEC_R.
  - 0x08, 0x0C, 0x0D, 0x0F: EXEC_I.
  - 0x23, 0x2B: MEM_ADDR.
  - 0x04, 0x05: BRANCH.
  - 0x02: JUMP.
  - 0x03: JAL.
  - Anything else: TRAP with cause 1.
- **Execute states:**
  - EXEC_R: alu_src_a = 1, alu_src_b = 0, alu_op = FUNCT, then WB_R.
  - SHIFT: as EXEC_R but alu_src_a = 2, then WB_R.
  - EXEC_I: alu_src_a = 1, alu_src_b = 2; alu_op = ADD / AND / OR / LUI for op 0x08 / 0x0C / 0x0D / 0x0F; then WB_I.
  - MEM_ADDR: alu_src_a = 1, alu_src_b = 2, alu_op = ADD. Next state MEM_RD (op 0x23) or MEM_WR (op 0x2B).
- **Memory states:** both use mem_req = 1, i_or_d = 1.
  - MEM_RD: waits for mem_ready, then WB_MEM.
  - MEM_WR: mem_we = 1; waits for mem_ready, then retires and returns to FETCH.
- **Write-back states:** each does reg_write = 1, then retires and returns to FETCH.
  - WB_R: reg_dst = 1, mem_to_reg = 0.
  - WB_I: reg_dst = 0, mem_to_reg = 0.
  - WB_MEM: reg_dst = 0, mem_to_reg = 1.
- **Control-flow states:** each retires and returns to FETCH.
  - BRANCH: alu_src_a = 1, alu_src_b = 0, alu_op = SUB, pc_src = 1. pc_write = zero for op 0x04, pc_write = !zero for op 0x05.
  - JUMP: pc_write = 1, pc_src = 2.
  - JR: pc_write = 1, pc_src = 3.
  - JAL: pc_write = 1, pc_src = 2, reg_write = 1, reg_dst = 2, mem_to_reg = 2. The register file samples PC+4 because the PC is updated at the same clock edge.
- **Retire:** instr_count increments by 1 on the final cycle of each instruction and wraps modulo 2^CNT_W.
- **Cycle counts with zero-wait memory:**
  - R-type, I-type, lw: 4 / 4 / 5 cycles.
  - sw, branch, j, jal, jr: 4 / 3 / 3 / 3 / 3 cycles.
- **Memory handshake:**
  - mem_req stays high and mem_we is stable until mem_ready is seen.
  - mem_ready when mem_req = 0 is ignored.
  - The timeout counter clears on every cycle with mem_req = 0 or mem_ready = 1.
  - If the counter reaches MEM_TIMEOUT while mem_ready = 0: go to TRAP with cause 2.
  - mem_ready arriving on the same cycle the counter reaches the limit counts as success (no trap).
- **TRAP:**
  - trap = 1; every enable is 0 and mem_req = 0.
  - Stays in TRAP until reset; the counter holds its value.
  - A reset during a pending memory request drops mem_req asynchronously.

Decomposition:
- Shared package holds:
  - opcode and funct constants;
  - alu_op codes: ADD = 0, SUB = 1, FUNCT = 2, OR = 3, AND = 4, LUI = 5;
  - mux select encodings;
  - trap cause codes;
  - the state enum (4-bit).
- One sub-module, mips_mem_timeout: the timeout counter with clear and expire outputs.
- The FSM's next-state logic and output decode live in the top module.

Test Plan:
- add (op 0x00, funct 0x20) with mem_ready tied to 1 → ir_write in cycle 0; reg_write = 1 with reg_dst = 1 in cycle 3; instr_count = 1 after 4 cycles.
- lw (op 0x23) with mem_ready delayed 3 cycles in MEM_RD → mem_req = 1 and i_or_d = 1 held for 4 cycles; WB_MEM has mem_to_reg = 1; total 8 cycles.
- beq with zero = 1, then bne with zero = 1 → pc_write = 1 with pc_src = 1 in the first case, pc_write = 0 in the second; both retire in 3 cycles.
- jal (op 0x03) → pc_write = 1, pc_src = 2, reg_write = 1, reg_dst = 2, mem_to_reg = 2 in a single cycle.
- op 0x3F → trap = 1, trap_cause = 1 after DECODE; all enables stay 0 for 20 cycles; reset = 0 clears trap and returns to FETCH.
- MEM_TIMEOUT = 4, mem_ready held 0 in FETCH → trap_cause = 2 on the 4th wait cycle. Repeat with mem_ready = 1 on that exact cycle → no trap, state DECODE.

Source files
------------

// File: rtl/mips_multicycle_control_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: opcode and funct
// constants, ALU operation classes, datapath mux encodings, trap causes and
// the controller state enum.
package mips_multicycle_control_pkg;

    // Opcodes (instruction bits [31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes that need their own path
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_JR    = 6'h08;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'd0,
        ALU_SUB   = 3'd1,
        ALU_FUNCT = 3'd2,
        ALU_OR    = 3'd3,
        ALU_AND   = 3'd4,
        ALU_LUI   = 3'd5
    } alu_op_e;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
    localparam logic [1:0] PC_SRC_RS     = 2'd3;

    localparam logic [1:0] REG_DST_RT    = 2'd0;
    localparam logic [1:0] REG_DST_RD    = 2'd1;
    localparam logic [1:0] REG_DST_RA    = 2'd2;

    localparam logic [1:0] WB_ALUOUT     = 2'd0;
    localparam logic [1:0] WB_MDR        = 2'd1;
    localparam logic [1:0] WB_PC         = 2'd2;

    localparam logic [1:0] SRCA_PC       = 2'd0;
    localparam logic [1:0] SRCA_RS       = 2'd1;
    localparam logic [1:0] SRCA_SHAMT    = 2'd2;

    localparam logic [1:0] SRCB_RT       = 2'd0;
    localparam logic [1:0] SRCB_FOUR     = 2'd1;
    localparam logic [1:0] SRCB_IMM      = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2  = 2'd3;

    typedef enum logic [1:0] {
        CAUSE_NONE        = 2'd0,
        CAUSE_ILLEGAL     = 2'd1,
        CAUSE_MEM_TIMEOUT = 2'd2
    } trap_cause_e;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_SHIFT, S_EXEC_I, S_MEM_ADDR,
        S_MEM_RD, S_MEM_WR, S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH,
        S_JUMP, S_JR, S_JAL, S_TRAP
    } state_e;

    // ALU class for the immediate-arithmetic group
    function automatic alu_op_e imm_alu_op(input logic [5:0] op);
        case (op)
            OP_ANDI: imm_alu_op = ALU_AND;
            OP_ORI:  imm_alu_op = ALU_OR;
            OP_LUI:  imm_alu_op = ALU_LUI;
            default: imm_alu_op = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mips_multicycle_control_mem_timeout.sv
// Memory wait-state watchdog.
// Ports:
//   clk, rst_n  : clock and asynchronous active-low reset
//   i_req       : a memory request is outstanding this cycle
//   i_ready     : memory completes the request this cycle
//   o_clear     : the counter restarts (no request, or request completed)
//   o_expire    : this is the last cycle the request may still be waiting;
//                 the caller traps if it is not also a clear cycle
module mips_mem_timeout #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_req,
    input  logic i_ready,
    output logic o_clear,
    output logic o_expire
);

    logic [7:0] r_count;

    assign o_clear  = !i_req || i_ready;
    assign o_expire = i_req && (r_count == 8'(MEM_TIMEOUT - 1));

    // Holds at the limit; the controller leaves the memory state on expiry,
    // which drops i_req and clears the count on the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (o_clear) begin
            r_count <= '0;
        end else if (!o_expire) begin
            r_count <= r_count + 8'd1;
        end
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle control FSM for a MIPS core with a shared variable-latency
// instruction/data memory.
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   op, funct, zero     : instruction fields from the IR and the ALU zero flag
//   mem_ready           : memory completes the current request
//   mem_req, mem_we,
//   i_or_d              : memory handshake and address select
//   ir_write, pc_write,
//   pc_src, reg_write,
//   reg_dst, mem_to_reg,
//   alu_src_a/b, alu_op : datapath enables, mux selects and ALU class
//   trap, trap_cause    : sticky fault flag and its cause
//   instr_count         : retired-instruction counter (wraps)
import mips_multicycle_control_pkg::*;

module mips_multicycle_control #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             reg_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instr_count
);

    state_e           r_state, w_next_state;
    logic             r_trap;
    trap_cause_e      r_trap_cause, w_cause;
    logic [CNT_W-1:0] r_instr_count;
    logic             w_retire, w_set_trap;
    logic             w_mem_req, w_mem_we, w_ir_write, w_pc_write, w_reg_write;
    logic             w_tmo_clear, w_tmo_expire, w_timeout;

    // Enables are masked by reset so a request in flight drops the moment
    // reset asserts, not at the next clock edge.
    assign mem_req   = w_mem_req   & reset;
    assign mem_we    = w_mem_we    & reset;
    assign ir_write  = w_ir_write  & reset;
    assign pc_write  = w_pc_write  & reset;
    assign reg_write = w_reg_write & reset;

    assign trap        = r_trap;
    assign trap_cause  = r_trap_cause;
    assign instr_count = r_instr_count;

    mips_mem_timeout #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_timeout (
        .clk      (clk),
        .rst_n    (reset),
        .i_req    (mem_req),
        .i_ready  (mem_ready),
        .o_clear  (w_tmo_clear),
        .o_expire (w_tmo_expire)
    );

    // Ready on the limit cycle is a clear cycle, so it wins over expiry.
    assign w_timeout = w_tmo_expire && !w_tmo_clear;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_FETCH;
            r_trap        <= 1'b0;
            r_trap_cause  <= CAUSE_NONE;
            r_instr_count <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_set_trap) begin
                r_trap       <= 1'b1;
                r_trap_cause <= w_cause;
            end
            if (w_retire) begin
                r_instr_count <= r_instr_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_retire     = 1'b0;
        w_set_trap   = 1'b0;
        w_cause      = CAUSE_NONE;
        w_mem_req    = 1'b0;
        w_mem_we     = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_reg_write  = 1'b0;
        i_or_d       = 1'b0;
        pc_src       = PC_SRC_ALU;
        reg_dst      = REG_DST_RT;
        mem_to_reg   = WB_ALUOUT;
        alu_src_a    = SRCA_PC;
        alu_src_b    = SRCB_RT;
        alu_op       = ALU_ADD;

        unique case (r_state)
            S_FETCH: begin
                w_mem_req = 1'b1;
                alu_src_b = SRCB_FOUR;
                if (mem_ready) begin
                    w_ir_write   = 1'b1;
                    w_pc_write   = 1'b1;
                    w_next_state = S_DECODE;
                end else if (w_timeout) begin
                    w_set_trap   = 1'b1;
                    w_cause      = CAUSE_MEM_TIMEOUT;
                    w_next_state = S_TRAP;
                end
            end
            S_DECODE: begin
                // Speculatively form the branch target into ALUOut
                alu_src_b = SRCB_IMM_SH2;
                if (op == OP_RTYPE) begin
                    if (funct == FN_JR)
                        w_next_state = S_JR;
                    else if (funct == FN_SLL || funct == FN_SRL)
                        w_next_state = S_SHIFT;
                    else
                        w_next_state = S_EXEC_R;
                end else begin
                    case (op)
                        OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: w_next_state = S_EXEC_I;
                        OP_LW, OP_SW:                     w_next_state = S_MEM_ADDR;
                        OP_BEQ, OP_BNE:                   w_next_state = S_BRANCH;
                        OP_J:                             w_next_state = S_JUMP;
                        OP_JAL:                           w_next_state = S_JAL;
                        default: begin
                            w_set_trap   = 1'b1;
                            w_cause      = CAUSE_ILLEGAL;
                            w_next_state = S_TRAP;
                        end
                    endcase
                end
            end
            S_EXEC_R, S_SHIFT: begin
                alu_src_a    = (r_state == S_SHIFT) ? SRCA_SHAMT : SRCA_RS;
                alu_op       = ALU_FUNCT;
                w_next_state = S_WB_R;
            end
            S_EXEC_I: begin
                alu_src_a    = SRCA_RS;
                alu_src_b    = SRCB_IMM;
                alu_op       = imm_alu_op(op);
                w_next_state = S_WB_I;
            end
            S_MEM_ADDR: begin
                alu_src_a    = SRCA_RS;
                alu_src_b    = SRCB_IMM;
                w_next_state = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD, S_MEM_WR: begin
                w_mem_req = 1'b1;
                w_mem_we  = (r_state == S_MEM_WR);
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    // A store has nothing to write back and retires here
                    w_retire     = (r_state == S_MEM_WR);
                    w_next_state = (r_state == S_MEM_WR) ? S_FETCH : S_WB_MEM;
                end else if (w_timeout) begin
                    w_set_trap   = 1'b1;
                    w_cause      = CAUSE_MEM_TIMEOUT;
                    w_next_state = S_TRAP;
                end
            end
            S_WB_R, S_WB_I, S_WB_MEM: begin
                w_reg_write  = 1'b1;
                reg_dst      = (r_state == S_WB_R)   ? REG_DST_RD : REG_DST_RT;
                mem_to_reg   = (r_state == S_WB_MEM) ? WB_MDR     : WB_ALUOUT;
                w_retire     = 1'b1;
                w_next_state = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a    = SRCA_RS;
                alu_op       = ALU_SUB;
                pc_src       = PC_SRC_ALUOUT;
                w_pc_write   = (op == OP_BEQ) ? zero : !zero;
                w_retire     = 1'b1;
                w_next_state = S_FETCH;
            end
            S_JUMP, S_JR: begin
                w_pc_write   = 1'b1;
                pc_src       = (r_state == S_JR) ? PC_SRC_RS : PC_SRC_JUMP;
                w_retire     = 1'b1;
                w_next_state = S_FETCH;
            end
            S_JAL: begin
                // The register file captures PC (already PC+4) on the same
                // edge that loads the jump target.
                w_pc_write   = 1'b1;
                pc_src       = PC_SRC_JUMP;
                w_reg_write  = 1'b1;
                reg_dst      = REG_DST_RA;
                mem_to_reg   = WB_PC;
                w_retire     = 1'b1;
                w_next_state = S_FETCH;
            end
            S_TRAP: begin
                w_next_state = S_TRAP;
            end
            default: begin
                w_next_state = S_FETCH;
            end
        endcase
    end

endmodule
